// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: takes FFT frames in bit-reversed order and emits them in natural order.
// One bank fills while the other is read out gaplessly through a registered output stage.
module bit_reverse_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_last
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } rd_state_t;

    logic [WIDTH-1:0] bank_re [0:2*N-1];
    logic [WIDTH-1:0] bank_im [0:2*N-1];

    logic [LOG_N-1:0] w;
    logic [LOG_N-1:0] r;
    logic             wb;
    logic             rb;
    rd_state_t        state;

    logic             frame_done;
    logic [LOG_N:0]   wr_addr;
    logic [LOG_N:0]   rd_addr;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] rev;
        rev = '0;
        for (int i = 0; i < LOG_N; i++) begin
            rev[i] = a[LOG_N-1-i];
        end
        return rev;
    endfunction

    assign frame_done = di_en && (w == LAST_IDX);
    assign wr_addr    = {wb, w};
    assign rd_addr    = {rb, bitrev(r)};

    // Sample storage carries no reset; bank bit selects the ping or pong half.
    always_ff @(posedge clock) begin
        if (di_en && !reset) begin
            bank_re[wr_addr] <= di_re;
            bank_im[wr_addr] <= di_im;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w       <= '0;
            r       <= '0;
            wb      <= 1'b0;
            rb      <= 1'b0;
            state   <= IDLE;
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            if (di_en) begin
                w <= w + 1'b1;
            end
            if (frame_done) begin
                wb <= ~wb;
            end

            if (state == ACTIVE) begin
                do_en   <= 1'b1;
                do_re   <= bank_re[rd_addr];
                do_im   <= bank_im[rd_addr];
                do_last <= (r == LAST_IDX);
            end else begin
                do_en   <= 1'b0;
                do_last <= 1'b0;
            end

            // A freshly completed frame takes priority so back-to-back frames stream without a gap.
            if (frame_done) begin
                rb    <= wb;
                r     <= '0;
                state <= ACTIVE;
            end else if (state == ACTIVE) begin
                r <= r + 1'b1;
                if (r == LAST_IDX) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Scoreboard bench for bit_reverse_reorder at LOG_N=3: expected natural-order outputs,
// with their exact output cycles, are queued when the final sample of a frame is driven.
module tb_bit_reverse_reorder;

    localparam int WIDTH = 16;
    localparam int LOG_N = 3;
    localparam int N     = 1 << LOG_N;

    logic             clock;
    logic             reset;
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             last;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_re [0:N-1];
    logic [WIDTH-1:0] model_im [0:N-1];
    int               wcnt;
    int               cyc;
    int               outputs_seen;
    int               tests_run;
    int               tests_failed;

    bit_reverse_reorder #(.WIDTH(WIDTH), .LOG_N(LOG_N)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of input; a completed frame queues its outputs in natural order.
    task automatic apply_stimulus(input logic en, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        logic [LOG_N-1:0] j;
        logic [LOG_N-1:0] rev;
        exp_t             e;
        @(posedge clock);
        #1;
        di_en = en;
        di_re = re;
        di_im = im;
        if (en) begin
            model_re[wcnt] = re;
            model_im[wcnt] = im;
            if (wcnt == N - 1) begin
                for (int k = 0; k < N; k++) begin
                    j   = LOG_N'(k);
                    rev = {j[0], j[1], j[2]};
                    e.re   = model_re[rev];
                    e.im   = model_im[rev];
                    e.last = (k == N - 1);
                    e.cyc  = cyc + 2 + k;
                    sb.push_back(e);
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0);
    endtask

    task automatic send_frame(input int base, input bit gapped);
        logic [WIDTH-1:0] v;
        for (int k = 0; k < N; k++) begin
            v = WIDTH'(base + k);
            apply_stimulus(1'b1, v, -v);
            if (gapped) apply_stimulus(1'b0, 16'hDEAD, 16'hBEEF);
        end
    endtask

    // Holds reset for two edges with di_en high to show it is ignored; model forgets everything.
    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        di_en = 1'b1;
        di_re = 16'h1234;
        di_im = 16'h5678;
        sb.delete();
        wcnt = 0;
        @(posedge clock);
        #1;
        check_output("rst_do_en", 32'(do_en), 32'd0);
        check_output("rst_do_last", 32'(do_last), 32'd0);
        check_output("rst_do_re", 32'(do_re), 32'd0);
        check_output("rst_do_im", 32'(do_im), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        di_en = 1'b0;
    endtask

    task automatic wait_outputs(input int target);
        int i;
        i = 0;
        while (outputs_seen < target && i < 100) begin
            @(posedge clock);
            #1;
            di_en = 1'b0;
            i++;
        end
        check_output("wait_outputs", 32'(outputs_seen >= target), 32'd1);
    endtask

    // Every non-reset cycle: do_en must be high exactly on the cycle the head entry is due.
    always @(negedge clock) begin
        exp_t e;
        logic exp_en;
        if (!reset) begin
            exp_en = (sb.size() > 0) && (sb[0].cyc == cyc);
            check_output("do_en", 32'(do_en), 32'(exp_en));
            if (exp_en) begin
                e = sb.pop_front();
                check_output("do_re", 32'(do_re), 32'(e.re));
                check_output("do_im", 32'(do_im), 32'(e.im));
                check_output("do_last", 32'(do_last), 32'(e.last));
                outputs_seen++;
            end else begin
                check_output("do_last_idle", 32'(do_last), 32'd0);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        tests_run    = 0;
        tests_failed = 0;
        outputs_seen = 0;
        wcnt  = 0;
        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;

        apply_reset();

        send_frame(0, 1'b0);
        idle(12);

        send_frame(0, 1'b0);
        send_frame(8, 1'b0);
        idle(12);

        send_frame(0, 1'b1);
        idle(12);

        send_frame(16, 1'b0);
        wait_outputs(outputs_seen + 4);
        apply_reset();
        idle(12);
        send_frame(24, 1'b0);
        idle(12);

        for (int k = 0; k < 5; k++) begin
            a = WIDTH'(100 + k);
            apply_stimulus(1'b1, a, -a);
        end
        apply_reset();
        send_frame(40, 1'b0);
        idle(12);

        for (int k = 0; k < N; k++) begin
            a = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            b = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
            apply_stimulus(1'b1, a, b);
        end
        idle(12);

        check_output("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bit_reverse_reorder.md
BIT_REVERSE_REORDER -- requirements
Module: bit_reverse_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of each real/imag data word.
REQ-002 SHALL have parameter LOG_N, default 6, meaning log2 of frame length N (N = 2**LOG_N, legal LOG_N 1..12).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port di_en  input  1  input sample valid.
REQ-006 SHALL have port di_re  input  WIDTH  input data, real, signed.
REQ-007 SHALL have port di_im  input  WIDTH  input data, imag, signed.
REQ-008 SHALL have port do_en  output  1  output sample valid.
REQ-009 SHALL have port do_re  output  WIDTH  output data, real, signed.
REQ-010 SHALL have port do_im  output  WIDTH  output data, imag, signed.
REQ-011 SHALL have port do_last  output  1  high with the final (N-th) output sample of a frame.

Function
REQ-012 SHALL accept FFT output frames in bit-reversed order and emit them in natural order: output j of a frame = input sample with index bitrev_LOG_N(j).
REQ-013 SHALL store samples in two banks of N complex words (ping-pong); write bank index wb and read bank index rb are 1-bit registers.
REQ-014 SHALL write each di_en sample to bank[wb][w], w a LOG_N-bit write counter, w incremented only when di_en=1.
REQ-015 SHALL, on the edge capturing w=N-1: wrap w to 0, toggle wb, set rb to the just-filled bank, set read state to ACTIVE with read counter r=0.
REQ-016 SHALL implement read FSM IDLE/ACTIVE: in ACTIVE read bank[rb][bitrev(r)] each cycle, increment r; on r=N-1 return to IDLE unless REQ-015 fires on the same edge (then restart r=0 on new rb).
REQ-017 SHALL register memory output: do_en, do_re, do_im, do_last updated one edge after the read address issue; do_last=1 exactly when r=N-1 was read.
REQ-018 SHALL make first output of a frame valid in cycle c+2, c = cycle in which sample N-1 is presented with di_en=1; N outputs then on N consecutive cycles with no gaps.
REQ-019 SHALL accept di_en with arbitrary gaps; read output stays gapless regardless of input gaps.
REQ-020 SHALL sustain back-to-back frames at one sample/cycle with zero lost samples; read of bank rb never overlaps writes to the same bank (guaranteed since a frame fill takes at least N cycles).
REQ-021 SHALL hold do_re/do_im at last value and do_en=0, do_last=0 when not outputting.
REQ-022 SHALL pass data unmodified (no rounding, scaling, or sign change); width WIDTH in and out.
REQ-023 SHALL read memory banks as plain registers/RAM inferred without reset; contents undefined until written.

Reset
REQ-024 SHALL, when reset=1 at an edge, set w=0, wb=0, rb=0, r=0, FSM=IDLE, do_en=0, do_last=0, do_re=0, do_im=0.
REQ-025 SHALL discard any partial input frame and abort any in-progress output on reset; do_en=0 from the cycle after the reset edge.
REQ-026 SHALL ignore di_en during reset cycles; first sample after reset deasserts is index 0 of a new frame.

Verification
REQ-027 SHALL verify LOG_N=3, 8 contiguous inputs re=k, im=-k (k=0..7) -> outputs re 0,4,2,6,1,5,3,7 (im negated), do_en high cycles c+2..c+9, do_last on 8th.
REQ-028 SHALL verify two back-to-back LOG_N=3 frames (re=k then re=8+k) -> 16 gapless outputs, second frame 8,12,10,14,9,13,11,15, do_last twice.
REQ-029 SHALL verify gapped input (di_en alternating 1/0, LOG_N=3) -> same order as REQ-027, output burst of 8 consecutive cycles starting c+2.
REQ-030 SHALL verify reset asserted after 4th output of a frame -> do_en=0 next cycle, no further outputs; subsequent full frame reorders correctly.
REQ-031 SHALL verify reset after 5 of 8 input samples -> partial frame never output; next 8 samples form frame 0.
REQ-032 SHALL verify extreme values re=0x7FFF/0x8000, im=0x8000/0x7FFF at WIDTH=16 -> emitted bit-exact.
